// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Single-cycle 32-bit arithmetic/logic unit. Each rising edge of clk the
//   result of (tr <op> sr) is captured into dr, along with a carry / borrow /
//   shift-out flag in cf. The only state is the pair of output registers.
//
// Ports
//   clk  in   1   system clock, rising edge
//   rst  in   1   synchronous active-high reset (dr = 0, cf = 0)
//   op   in   4   operation select
//   tr   in  32   first operand
//   sr   in  32   second operand / shift amount (sr[4:0])
//   dr   out 32   registered result
//   cf   out  1   registered carry / borrow / shift-out flag
// -----------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic [31:0] tr,
    input  logic [31:0] sr,
    output logic [31:0] dr,
    output logic        cf
);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOT = 4'b0101,
        OP_MOV = 4'b0110,
        OP_NOR = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010,
        OP_ROL = 4'b1011
    } op_e;

    logic [31:0] dr_d, dr_q;
    logic        cf_d, cf_q;

    logic [4:0]  n;
    logic [5:0]  n_inv;     // 32 - n; equals 32 when n == 0 so the wrap term vanishes
    logic [32:0] add_w;
    logic [32:0] sub_w;
    logic [32:0] sll_w;     // bit 32 catches the last bit shifted out the top
    logic [32:0] srl_w;     // bit 0 catches the last bit shifted out the bottom
    logic [32:0] sra_w;
    logic [31:0] rol_w;

    always_comb begin
        n     = sr[4:0];
        n_inv = 6'd32 - {1'b0, n};
        add_w = {1'b0, tr} + {1'b0, sr};
        // Bit 32 of the extended difference is the unsigned borrow.
        sub_w = {1'b0, tr} - {1'b0, sr};
        // With n == 0 the capture bits stay zero, giving dr = tr, cf = 0.
        sll_w = {1'b0, tr} << n;
        srl_w = {tr, 1'b0} >> n;
        sra_w = 33'($signed({tr, 1'b0}) >>> n);
        rol_w = (tr << n) | (tr >> n_inv);
    end

    always_comb begin
        dr_d = '0;
        cf_d = 1'b0;
        case (op)
            OP_ADD: {cf_d, dr_d} = add_w;
            OP_SUB: {cf_d, dr_d} = sub_w;
            OP_AND: dr_d = tr & sr;
            OP_OR:  dr_d = tr | sr;
            OP_XOR: dr_d = tr ^ sr;
            OP_NOT: dr_d = ~tr;
            OP_MOV: dr_d = sr;
            OP_NOR: dr_d = ~(tr | sr);
            OP_SLL: {cf_d, dr_d} = sll_w;
            OP_SRL: begin
                dr_d = srl_w[32:1];
                cf_d = srl_w[0];
            end
            OP_SRA: begin
                dr_d = sra_w[32:1];
                cf_d = sra_w[0];
            end
            OP_ROL: begin
                dr_d = rol_w;
                cf_d = (n != 5'd0) & rol_w[0];
            end
            // Reserved and unknown opcodes produce zero.
            default: begin
                dr_d = '0;
                cf_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_q <= '0;
            cf_q <= 1'b0;
        end else begin
            dr_q <= dr_d;
            cf_q <= cf_d;
        end
    end

    assign dr = dr_q;
    assign cf = cf_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] tr;
    logic [31:0] sr;
    logic [31:0] dr;
    logic        cf;

    int n_chk  = 0;
    int n_fail = 0;

    alu dut (
        .clk (clk),
        .rst (rst),
        .op  (op),
        .tr  (tr),
        .sr  (sr),
        .dr  (dr),
        .cf  (cf)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic. Returns {cf, dr}.
    function automatic logic [32:0] ref_alu(input logic [3:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        A, B, p;
        logic signed [63:0] s;
        int                 k;
        A = {32'd0, a};
        B = {32'd0, b};
        k = int'(b[4:0]);
        case (o)
            4'd0: begin p = A + B; return p[32:0]; end
            4'd1: begin p = A - B; return {(a < b), p[31:0]}; end
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, ~a};
            4'd6: return {1'b0, b};
            4'd7: return {1'b0, ~(a | b)};
            4'd8: begin
                if (k == 0) return {1'b0, a};
                p = A * (64'd1 << k);
                return p[32:0];
            end
            4'd9: begin
                if (k == 0) return {1'b0, a};
                p = A / (64'd1 << (k - 1));
                return {p[0], p[32:1]};
            end
            4'd10: begin
                if (k == 0) return {1'b0, a};
                s = 64'(signed'(a));
                s = s >>> (k - 1);
                return {s[0], s[32:1]};
            end
            4'd11: begin
                if (k == 0) return {1'b0, a};
                p = A * (64'd1 << k);
                // Bits pushed past bit 31 wrap back to the bottom.
                p[31:0] = p[31:0] | p[63:32];
                return {p[0], p[31:0]};
            end
            default: return 33'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] exp_dr, input logic exp_cf);
        n_chk++;
        assert (dr === exp_dr && cf === exp_cf) else begin
            n_fail++;
            $error("FAIL %s: got dr=%h cf=%b, expected dr=%h cf=%b", tag, dr, cf, exp_dr, exp_cf);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o;
        tr = a;
        sr = b;
        @(posedge clk);
        #1;
    endtask

    // Directed step with an expected value written out by hand.
    task automatic step(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_dr, input logic exp_cf);
        drive(o, a, b);
        check(tag, exp_dr, exp_cf);
    endtask

    initial begin
        logic [32:0] e;
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        // Reset held two edges with an ADD presented.
        rst = 1'b1; op = 4'd0; tr = 32'd5; sr = 32'd7;
        @(posedge clk); @(posedge clk); #1;
        check("reset", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_after_reset", 32'd12, 1'b0);

        // Arithmetic
        step("add",      4'd0, 32'd32, 32'd21, 32'd53, 1'b0);
        step("sub",      4'd1, 32'd32, 32'd21, 32'd11, 1'b0);
        step("sub_brw",  4'd1, 32'd21, 32'd32, 32'hFFFFFFF5, 1'b1);
        step("add_cy",   4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);

        // Logic
        step("and", 4'd2, 32'd32, 32'd21, 32'd0, 1'b0);
        step("or",  4'd3, 32'd32, 32'd21, 32'd53, 1'b0);
        step("xor", 4'd4, 32'd32, 32'd21, 32'd53, 1'b0);
        step("not", 4'd5, 32'd32, 32'd21, 32'hFFFFFFDF, 1'b0);
        step("mov", 4'd6, 32'd32, 32'd21, 32'd21, 1'b0);
        step("nor", 4'd7, 32'd32, 32'd21, 32'hFFFFFFCA, 1'b0);

        // Shifts
        step("sll", 4'd8,  32'd32, 32'd3, 32'd256, 1'b0);
        step("srl", 4'd9,  32'd32, 32'd3, 32'd4, 1'b0);
        step("sra", 4'd10, 32'd32, 32'd3, 32'd4, 1'b0);
        step("rol", 4'd11, 32'd32, 32'd3, 32'd256, 1'b0);

        // Shift edge cases
        step("sra_sign", 4'd10, 32'h80000001, 32'd1, 32'hC0000000, 1'b1);
        step("sll_out",  4'd8,  32'h80000001, 32'd1, 32'd2, 1'b1);
        step("rol_wrap", 4'd11, 32'h80000001, 32'd1, 32'd3, 1'b1);
        step("srl_out",  4'd9,  32'h80000001, 32'd1, 32'h40000000, 1'b1);
        step("sll_n0",   4'd8,  32'h80000001, 32'd32, 32'h80000001, 1'b0);
        step("srl_n0",   4'd9,  32'h80000001, 32'd32, 32'h80000001, 1'b0);
        step("sra_n0",   4'd10, 32'h80000001, 32'd32, 32'h80000001, 1'b0);
        step("rol_n0",   4'd11, 32'h80000001, 32'd32, 32'h80000001, 1'b0);
        step("sll_31",   4'd8,  32'h00000003, 32'd31, 32'h80000000, 1'b1);
        step("sra_31",   4'd10, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);

        // Reserved opcodes
        step("rsv_c", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0);
        step("rsv_d", 4'd13, 32'h12345678, 32'd1, 32'd0, 1'b0);
        step("rsv_e", 4'd14, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        step("rsv_f", 4'd15, 32'hDEADBEEF, 32'd5, 32'd0, 1'b0);

        // Outputs hold when inputs change mid-cycle.
        step("pre_hold", 4'd0, 32'd100, 32'd23, 32'd123, 1'b0);
        @(negedge clk);
        op = 4'd6; tr = 32'd0; sr = 32'hA5A5A5A5;
        #2;
        check("hold", 32'd123, 1'b0);
        @(posedge clk); #1;
        check("hold_next", 32'hA5A5A5A5, 1'b0);

        // Reset overrides a live operation.
        @(negedge clk);
        rst = 1'b1; op = 4'd0; tr = 32'hFFFFFFFF; sr = 32'd1;
        @(posedge clk); #1;
        check("reset_override", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized back-to-back traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i % 17 == 0) ra = 32'hFFFFFFFF;
            drive(ro, ra, rb);
            e = ref_alu(ro, ra, rb);
            check($sformatf("rand%0d_op%0d", i, ro), e[31:0], e[32]);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
# alu

Single-cycle 32-bit arithmetic/logic unit for the datapath. Each clock it combines operand `tr` with operand `sr` under the 4-bit opcode `op`. It registers the 32-bit result on `dr` and a carry/borrow/shift-out flag on `cf`. It has no internal state beyond the two output registers.

## Interface

Parameters: none (width fixed at 32).

- `clk`  input  1  system clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `op`  input  4  operation select
- `tr`  input  32  first operand (target register value)
- `sr`  input  32  second operand (source register value / shift amount)
- `dr`  output  32  registered result
- `cf`  output  1  registered carry/borrow/shift-out flag

## Operation

Opcode table (`n = sr[4:0]`; unused `sr` bits ignored for shifts):

- `0000` ADD: `dr = tr + sr`; `cf` = carry out of bit 31.
- `0001` SUB: `dr = tr - sr`; `cf` = 1 when `tr < sr` unsigned (borrow), else 0.
- `0010` AND: `dr = tr & sr`; `cf` = 0.
- `0011` OR: `dr = tr | sr`; `cf` = 0.
- `0100` XOR: `dr = tr ^ sr`; `cf` = 0.
- `0101` NOT: `dr = ~tr`; `cf` = 0.
- `0110` MOV: `dr = sr`; `cf` = 0.
- `0111` NOR: `dr = ~(tr | sr)`; `cf` = 0.
- `1000` SLL: `dr = tr << n`, zero fill; `cf = tr[32-n]` for n≠0.
- `1001` SRL: `dr = tr >> n`, zero fill; `cf = tr[n-1]` for n≠0.
- `1010` SRA: `dr = tr >>> n`, sign fill from `tr[31]`; `cf = tr[n-1]` for n≠0.
- `1011` ROL: `dr = (tr << n) | (tr >> (32-n))`; `cf = dr_next[0]` for n≠0.
- `1100`–`1111` reserved: `dr = 0`, `cf = 0`.
- Shift/rotate with n = 0: `dr = tr`, `cf = 0`.
- All arithmetic is unsigned modulo 2^32, except SRA sign fill.
- No signed-overflow flag.

## Timing

- Inputs are sampled on the rising edge of `clk`. `dr`/`cf` reflect that edge's `op`/`tr`/`sr` from the edge onward, so latency is 1 cycle.
- Throughput: one operation per cycle. There is no handshake; a new op is accepted every edge.
- Reset: when `rst`=1 at a rising edge, `dr` becomes 0 and `cf` becomes 0, regardless of `op`. Reset overrides any operation in the same cycle.
- Reset deasserted: the first edge with `rst`=0 computes normally.
- Outputs hold between edges. Input changes between edges have no effect until the next edge.
- X/undefined `op` after reset is treated like a reserved code: `dr` = 0, `cf` = 0.

## Test plan

- Reset: `rst`=1 for 2 cycles with `op`=ADD, `tr`=5, `sr`=7 -> `dr`=0, `cf`=0. The first edge after release gives `dr`=12.
- Arithmetic, `tr`=32, `sr`=21:
  - ADD -> 53, cf 0.
  - SUB -> 11, cf 0.
  - Swapped operands (`tr`=21, `sr`=32), SUB -> 0xFFFFFFF5, cf 1.
  - `tr`=0xFFFFFFFF, `sr`=1, ADD -> 0, cf 1.
- Logic, `tr`=32, `sr`=21, all with cf 0:
  - AND -> 0
  - OR -> 53
  - XOR -> 53
  - NOT -> 0xFFFFFFDF
  - MOV -> 21
  - NOR -> 0xFFFFFFCA
- Shifts, `tr`=32, `sr`=3:
  - SLL -> 256, cf 0
  - SRL -> 4, cf 0
  - SRA -> 4, cf 0
  - ROL -> 256, cf 0
- Shift edge cases:
  - `tr`=0x80000001, `sr`=1: SRA -> 0xC0000000, cf 1; SLL -> 2, cf 1; ROL -> 3, cf 1.
  - `sr`=32 (n=0) -> `dr`=`tr`, cf 0.
- Back-to-back and reserved:
  - Change `op` every cycle -> each result appears exactly one edge later.
  - `op`=1100..1111 -> `dr`=0, cf 0.
